// File: rtl/axi_rd_arbiter.sv
// AXI read-channel arbiter: client vs prefetcher onto one memory AR port.
// R beats are routed back by an in-order source-tag FIFO.
module axi_rd_arbiter #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 3,
  parameter int LOG_OUTSTANDING      = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  // client AR
  input  logic                         c_ar_valid,
  output logic                         c_ar_ready,
  input  logic [ADDR_BITS-1:0]         c_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   c_ar_len,
  input  logic [TID_WIDTH-1:0]         c_ar_id,
  // prefetcher AR
  input  logic                         p_ar_valid,
  output logic                         p_ar_ready,
  input  logic [ADDR_BITS-1:0]         p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   p_ar_len,
  input  logic [TID_WIDTH-1:0]         p_ar_id,
  // memory AR
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [ADDR_BITS-1:0]         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
  output logic [TID_WIDTH-1:0]         m_ar_id,
  // memory R
  input  logic                         m_r_valid,
  output logic                         m_r_ready,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
  input  logic                         m_r_last,
  input  logic [TID_WIDTH-1:0]         m_r_id,
  // client R
  output logic                         c_r_valid,
  input  logic                         c_r_ready,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] c_r_data,
  output logic                         c_r_last,
  output logic [TID_WIDTH-1:0]         c_r_id,
  // prefetcher R
  output logic                         p_r_valid,
  input  logic                         p_r_ready,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] p_r_data,
  output logic                         p_r_last,
  output logic [TID_WIDTH-1:0]         p_r_id,
  // control / status
  input  logic [3:0]                   starveLimit,
  output logic [LOG_OUTSTANDING:0]     outstandingCnt,
  output logic                         tagFull,
  output logic                         protocolErr
);

  localparam int DEPTH = 1 << LOG_OUTSTANDING;
  localparam logic [LOG_OUTSTANDING:0] DEPTH_C =
    {1'b1, {LOG_OUTSTANDING{1'b0}}};

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                       state_q;
  logic                         m_ar_valid_q;
  logic [ADDR_BITS-1:0]         m_ar_addr_q;
  logic [BURST_LEN_WIDTH-1:0]   m_ar_len_q;
  logic [TID_WIDTH-1:0]         m_ar_id_q;

  logic [3:0]                   starve_q;
  logic [3:0]                   starve_d;

  logic [DEPTH-1:0]             tag_q;
  logic [LOG_OUTSTANDING-1:0]   wptr_q;
  logic [LOG_OUTSTANDING-1:0]   rptr_q;
  logic [LOG_OUTSTANDING:0]     cnt_q;
  logic [LOG_OUTSTANDING:0]     cnt_d;
  logic                         perr_q;

  logic full;
  logic empty;
  logic age_hit;
  logic pick_p;
  logic grant;
  logic head;
  logic push;
  logic pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);

  // Prefetcher wins when alone, or when it has aged past the limit.
  assign age_hit = (starveLimit != 4'd0) && (starve_q >= starveLimit);
  assign pick_p  = p_ar_valid && (!c_ar_valid || age_hit);
  assign grant   = (state_q == IDLE) && !full
                && (c_ar_valid || p_ar_valid);

  assign c_ar_ready = grant && !pick_p;
  assign p_ar_ready = grant && pick_p;

  assign m_ar_valid = m_ar_valid_q;
  assign m_ar_addr  = m_ar_addr_q;
  assign m_ar_len   = m_ar_len_q;
  assign m_ar_id    = m_ar_id_q;

  // AR FSM: latch the winner's payload, hold it until memory accepts.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      m_ar_valid_q <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
      m_ar_id_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q      <= ISSUE;
            m_ar_valid_q <= 1'b1;
            if (pick_p) begin
              m_ar_addr_q <= p_ar_addr;
              m_ar_len_q  <= p_ar_len;
              m_ar_id_q   <= p_ar_id;
            end else begin
              m_ar_addr_q <= c_ar_addr;
              m_ar_len_q  <= c_ar_len;
              m_ar_id_q   <= c_ar_id;
            end
          end
        end
        ISSUE: begin
          if (m_ar_ready) begin
            state_q      <= IDLE;
            m_ar_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          m_ar_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Aging counter: counts client wins that passed over a waiting prefetcher.
  always_comb begin
    starve_d = starve_q;
    if (grant && pick_p) begin
      starve_d = 4'd0;
    end else if (grant && p_ar_valid) begin
      if (starve_q != 4'hf) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Aging counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // R routing follows the oldest outstanding burst's source tag.
  assign head = tag_q[rptr_q];

  assign c_r_valid = !empty && !head && m_r_valid;
  assign p_r_valid = !empty &&  head && m_r_valid;
  assign m_r_ready = !empty && (head ? p_r_ready : c_r_ready);

  assign c_r_data = m_r_data;
  assign c_r_last = m_r_last;
  assign c_r_id   = m_r_id;
  assign p_r_data = m_r_data;
  assign p_r_last = m_r_last;
  assign p_r_id   = m_r_id;

  assign push = grant;
  assign pop  = m_r_valid && m_r_ready && m_r_last;

  // Occupancy next-state for push/pop combinations.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag FIFO storage and pointers; pointers wrap naturally.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= pick_p;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  // Sticky flag: a beat arrived with nothing outstanding.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      perr_q <= 1'b0;
    end else if (empty && m_r_valid) begin
      perr_q <= 1'b1;
    end
  end

  assign outstandingCnt = cnt_q;
  assign tagFull        = full;
  assign protocolErr    = perr_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with a small in-order memory model.
// Tag FIFO depth is 2 here so the full case is reachable.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        resetN;
  logic        c_ar_valid, c_ar_ready;
  logic [63:0] c_ar_addr;
  logic [7:0]  c_ar_len, c_ar_id;
  logic        p_ar_valid, p_ar_ready;
  logic [63:0] p_ar_addr;
  logic [7:0]  p_ar_len, p_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [63:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid, m_r_ready;
  logic [63:0] m_r_data;
  logic        m_r_last;
  logic [7:0]  m_r_id;
  logic        c_r_valid, c_r_ready;
  logic [63:0] c_r_data;
  logic        c_r_last;
  logic [7:0]  c_r_id;
  logic        p_r_valid, p_r_ready;
  logic [63:0] p_r_data;
  logic        p_r_last;
  logic [7:0]  p_r_id;
  logic [3:0]  starveLimit;
  logic [1:0]  outstandingCnt;
  logic        tagFull;
  logic        protocolErr;

  axi_rd_arbiter #(.LOG_OUTSTANDING(1)) dut (
    .clk(clk), .resetN(resetN),
    .c_ar_valid(c_ar_valid), .c_ar_ready(c_ar_ready),
    .c_ar_addr(c_ar_addr), .c_ar_len(c_ar_len), .c_ar_id(c_ar_id),
    .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready),
    .p_ar_addr(p_ar_addr), .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .c_r_valid(c_r_valid), .c_r_ready(c_r_ready),
    .c_r_data(c_r_data), .c_r_last(c_r_last), .c_r_id(c_r_id),
    .p_r_valid(p_r_valid), .p_r_ready(p_r_ready),
    .p_r_data(p_r_data), .p_r_last(p_r_last), .p_r_id(p_r_id),
    .starveLimit(starveLimit),
    .outstandingCnt(outstandingCnt),
    .tagFull(tagFull),
    .protocolErr(protocolErr)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  id;
  } r_t;

  bit  exp_g[$];
  ar_t exp_ar[$];
  r_t  exp_c[$];
  r_t  exp_p[$];
  ar_t bq[$];

  int checks = 0;
  int errors = 0;
  int ngrant = 0;
  bit mem_hold = 0;
  bit err_inj = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got unexpected-event exp none", nm);
  endtask

  task automatic flush();
    exp_g.delete();
    exp_ar.delete();
    exp_c.delete();
    exp_p.delete();
  endtask

  // Expected grant, AR payload and R beats (data = addr + beat).
  task automatic expect_burst(input bit src, input logic [63:0] a,
                              input logic [7:0] l, input logic [7:0] i);
    r_t r;
    exp_g.push_back(src);
    exp_ar.push_back('{addr: a, len: l, id: i});
    for (int b = 0; b <= int'(l); b++) begin
      r.data = a + 64'(b);
      r.last = (b == int'(l));
      r.id   = i;
      if (src) exp_p.push_back(r);
      else     exp_c.push_back(r);
    end
  endtask

  task automatic drive(input bit src, input logic [63:0] a,
                       input logic [7:0] l, input logic [7:0] i);
    if (src) begin
      p_ar_valid = 1'b1; p_ar_addr = a; p_ar_len = l; p_ar_id = i;
    end else begin
      c_ar_valid = 1'b1; c_ar_addr = a; c_ar_len = l; c_ar_id = i;
    end
  endtask

  // Wait for the source's ready, then drop its valid after the edge.
  task automatic wait_ready(input bit src);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      n++;
      if (tagFull) chk("full_block", c_ar_ready | p_ar_ready, 0);
      ok = src ? p_ar_ready : c_ar_ready;
    end
    chk(src ? "p_grant_wait" : "c_grant_wait", ok, 1);
    @(posedge clk); #1;
    if (src) p_ar_valid = 1'b0;
    else     c_ar_valid = 1'b0;
  endtask

  task automatic send(input bit src, input logic [63:0] a,
                      input logic [7:0] l, input logic [7:0] i);
    expect_burst(src, a, l, i);
    drive(src, a, l, i);
    wait_ready(src);
  endtask

  task automatic wait_grants(input int target);
    int n;
    n = 0;
    while (ngrant < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("grant_count", ngrant, target);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_g.size() + exp_ar.size() + exp_c.size()
            + exp_p.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_g.size() + exp_ar.size() + exp_c.size()
                 + exp_p.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: compare every grant, AR handshake and routed R beat.
  initial begin
    forever begin
      @(negedge clk);
      if (resetN) begin
        if (c_ar_ready || p_ar_ready) begin
          ngrant++;
          if (exp_g.size() == 0) unexp("grant");
          else chk("grant_src", p_ar_ready, exp_g.pop_front());
        end
        if (m_ar_valid && m_ar_ready) begin
          if (exp_ar.size() == 0) unexp("m_ar");
          else chk("m_ar_payload", {m_ar_addr, m_ar_len, m_ar_id},
                   exp_ar.pop_front());
        end
        if (c_r_valid && c_r_ready) begin
          if (exp_c.size() == 0) unexp("c_r");
          else chk("c_r_beat", {c_r_data, c_r_last, c_r_id},
                   exp_c.pop_front());
        end
        if (p_r_valid && p_r_ready) begin
          if (exp_p.size() == 0) unexp("p_r");
          else chk("p_r_beat", {p_r_data, p_r_last, p_r_id},
                   exp_p.pop_front());
        end
      end
    end
  end

  // In-order memory: answers each accepted AR with len+1 beats.
  initial begin
    bit  arf, rf;
    ar_t ab;
    int  beat;
    beat = 0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_last = 1'b0; m_r_id = '0;
    forever begin
      @(negedge clk);
      arf = m_ar_valid && m_ar_ready;
      ab  = '{addr: m_ar_addr, len: m_ar_len, id: m_ar_id};
      rf  = m_r_valid && m_r_ready;
      @(posedge clk);
      if (!resetN) begin
        bq.delete();
        beat = 0;
      end else begin
        if (rf && bq.size() != 0) begin
          if (beat == int'(bq[0].len)) begin
            void'(bq.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        if (arf) bq.push_back(ab);
      end
      #1;
      if (err_inj) begin
        m_r_valid = 1'b1; m_r_data = '0; m_r_last = 1'b1; m_r_id = '0;
      end else if (!mem_hold && resetN && bq.size() != 0) begin
        m_r_valid = 1'b1;
        m_r_data  = bq[0].addr + 64'(beat);
        m_r_last  = (beat == int'(bq[0].len));
        m_r_id    = bq[0].id;
      end else begin
        m_r_valid = 1'b0;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int base;
    resetN = 1'b0;
    c_ar_valid = 0; c_ar_addr = '0; c_ar_len = '0; c_ar_id = '0;
    p_ar_valid = 0; p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
    m_ar_ready = 1'b1;
    c_r_ready = 1'b1;
    p_r_ready = 1'b1;
    starveLimit = 4'd0;
    #1;
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_m_ar_addr", m_ar_addr, 0);
    chk("rst_outstanding", outstandingCnt, 0);
    chk("rst_tagfull", tagFull, 0);
    chk("rst_perr", protocolErr, 0);
    chk("rst_ready", {c_ar_ready, p_ar_ready}, 0);
    chk("rst_r_valid", {c_r_valid, p_r_valid}, 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;

    // single client read
    send(0, 64'hdeadbeef, 8'd0, 8'd5);
    chk("lat_m_ar_valid", m_ar_valid, 1);
    chk("lat_m_ar_addr", m_ar_addr, 64'hdeadbeef);
    chk("lat_outstanding", outstandingCnt, 1);
    drain();
    chk("single_done_cnt", outstandingCnt, 0);

    // interleaved bursts
    send(0, 64'h1000, 8'd3, 8'd3);
    send(1, 64'h2000, 8'd1, 8'd4);
    drain();

    // contention, limit 3: C C C P C C C P
    do_reset();
    starveLimit = 4'd3;
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 7) expect_burst(1, 64'h200, 8'd0, 8'd2);
      else                  expect_burst(0, 64'h100, 8'd0, 8'd1);
    end
    base = ngrant;
    drive(0, 64'h100, 8'd0, 8'd1);
    drive(1, 64'h200, 8'd0, 8'd2);
    wait_grants(base + 8);
    c_ar_valid = 1'b0;
    p_ar_valid = 1'b0;
    drain();

    // contention, limit 0: prefetcher waits for the client to leave
    starveLimit = 4'd0;
    for (int k = 0; k < 6; k++) expect_burst(0, 64'h100, 8'd0, 8'd1);
    expect_burst(1, 64'h200, 8'd0, 8'd2);
    base = ngrant;
    drive(0, 64'h100, 8'd0, 8'd1);
    drive(1, 64'h200, 8'd0, 8'd2);
    wait_grants(base + 6);
    c_ar_valid = 1'b0;
    wait_grants(base + 7);
    p_ar_valid = 1'b0;
    drain();

    // full tag FIFO
    mem_hold = 1'b1;
    send(0, 64'h300, 8'd0, 8'd1);
    send(0, 64'h310, 8'd1, 8'd2);
    chk("full_flag", tagFull, 1);
    chk("full_cnt", outstandingCnt, 2);
    expect_burst(0, 64'h320, 8'd0, 8'd3);
    drive(0, 64'h320, 8'd0, 8'd3);
    repeat (3) begin
      @(negedge clk);
      chk("full_no_ready", c_ar_ready, 0);
    end
    mem_hold = 1'b0;
    wait_ready(0);
    drain();

    // AR and R backpressure
    m_ar_ready = 1'b0;
    send(0, 64'h400, 8'd0, 8'd7);
    expect_burst(1, 64'h500, 8'd0, 8'd8);
    drive(1, 64'h500, 8'd0, 8'd8);
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_ar_valid", m_ar_valid, 1);
      chk("bp_m_ar_addr", m_ar_addr, 64'h400);
      chk("bp_no_grant", {c_ar_ready, p_ar_ready}, 0);
    end
    @(posedge clk); #1;
    m_ar_ready = 1'b1;
    c_r_ready = 1'b0;
    wait_ready(1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_c_r_valid", c_r_valid, 1);
      chk("bp_m_r_ready", m_r_ready, 0);
      chk("bp_p_r_valid", p_r_valid, 0);
    end
    @(posedge clk); #1;
    c_r_ready = 1'b1;
    drain();

    // protocol error with empty FIFO
    @(negedge clk);
    err_inj = 1'b1;
    @(negedge clk);
    chk("err_r_valid", {c_r_valid, p_r_valid}, 0);
    chk("err_m_r_ready", m_r_ready, 0);
    err_inj = 1'b0;
    @(negedge clk);
    chk("err_set", protocolErr, 1);
    repeat (2) @(negedge clk);
    chk("err_sticky", protocolErr, 1);

    // reset while in ISSUE
    @(posedge clk); #1;
    m_ar_ready = 1'b0;
    send(0, 64'h600, 8'd0, 8'd1);
    @(negedge clk);
    chk("pre_rst_valid", m_ar_valid, 1);
    #2;
    resetN = 1'b0;
    flush();
    #1;
    chk("arst_m_ar_valid", m_ar_valid, 0);
    chk("arst_outstanding", outstandingCnt, 0);
    chk("arst_perr", protocolErr, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    m_ar_ready = 1'b1;
    @(posedge clk); #1;

    // recovery after reset
    send(1, 64'h700, 8'd1, 8'd9);
    drain();
    chk("final_cnt", outstandingCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
